// File: rtl/tuner_note_ctrl.sv
// Single-string tuning controller: averages measured periods and drives note/status digit codes.
// Optional AUTO_STRING_EN: string_sel follows the target nearest to each batch average.
module tuner_note_ctrl #(
    parameter int          W         = 20,
    parameter int          AVG_LOG2  = 2,
    parameter int          TOL_SHIFT = 7,
    parameter int unsigned TIMEOUT   = 25000000,
    parameter int unsigned T0        = 606722,
    parameter int unsigned T1        = 454545,
    parameter int unsigned T2        = 340530,
    parameter int unsigned T3        = 255102,
    parameter int unsigned T4        = 202478,
    parameter int unsigned T5        = 151685
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         string_next,
    input  logic         period_valid,
    input  logic [W-1:0] period,
    output logic [2:0]   string_sel,
    output logic [3:0]   note_code,
    output logic [3:0]   status_code,
    output logic         in_tune,
    output logic         result_pulse
);
    localparam int AW = W + AVG_LOG2;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);
    localparam logic [W-1:0] TGT [0:5] = '{W'(T0), W'(T1), W'(T2), W'(T3), W'(T4), W'(T5)};

    localparam logic [3:0] ST_FLAT  = 4'h6;
    localparam logic [3:0] ST_SHARP = 4'h7;
    localparam logic [3:0] ST_TUNED = 4'hE;
    localparam logic [3:0] ST_NOSIG = 4'hF;

    logic [AW-1:0]     acc;
    logic [AVG_LOG2:0] cnt;
    logic [IW-1:0]     idle;
    logic              adv, accept, eval;
    logic [AW-1:0]     sum;
    logic [W-1:0]      avg, tgt, tol, lo, diff, best_diff;
    logic [W:0]        hi;
    logic [2:0]        best;
    logic [3:0]        code;
    logic [IW-1:0]     idle_inc;

`ifdef AUTO_STRING_EN
    logic unused_string_next;
    assign unused_string_next = string_next;
    assign adv = 1'b0;
`else
    assign adv = string_next;
`endif

    // A string change in the same cycle as a sample discards the sample.
    assign accept   = period_valid && (period != '0) && !adv;
    assign sum      = acc + AW'(period);
    assign eval     = accept && (cnt == LAST);
    assign avg      = W'(sum >> AVG_LOG2);
    assign idle_inc = (idle == IW'(TIMEOUT)) ? idle : idle + 1'b1;
    assign note_code = {1'b0, string_sel};

    always_comb begin
        best      = string_sel;
        diff      = '0;
        best_diff = '0;
`ifdef AUTO_STRING_EN
        // Strict compare while scanning upward keeps ties on the lower index.
        for (int i = 0; i < 6; i++) begin
            diff = (avg >= TGT[i]) ? avg - TGT[i] : TGT[i] - avg;
            if (i == 0 || diff < best_diff) begin
                best_diff = diff;
                best      = 3'(i);
            end
        end
`endif
        tgt = TGT[best];
        tol = tgt >> TOL_SHIFT;
        hi  = {1'b0, tgt} + {1'b0, tol};
        lo  = tgt - tol;
        if ({1'b0, avg} > hi)
            code = ST_FLAT;
        else if (avg < lo)
            code = ST_SHARP;
        else
            code = ST_TUNED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            string_sel   <= '0;
            status_code  <= ST_NOSIG;
            in_tune      <= 1'b0;
            result_pulse <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            idle         <= '0;
        end else begin
            result_pulse <= 1'b0;
            if (adv) begin
                string_sel  <= (string_sel == 3'd5) ? 3'd0 : string_sel + 3'd1;
                status_code <= ST_NOSIG;
                in_tune     <= 1'b0;
                acc         <= '0;
                cnt         <= '0;
                idle        <= idle_inc;
            end else if (accept) begin
                idle <= '0;
                if (eval) begin
                    acc          <= '0;
                    cnt          <= '0;
                    string_sel   <= best;
                    status_code  <= code;
                    in_tune      <= (code == ST_TUNED);
                    result_pulse <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end else if (idle == IW'(TIMEOUT - 1)) begin
                // Silence long enough: drop to no-signal once, then hold.
                idle        <= IW'(TIMEOUT);
                status_code <= ST_NOSIG;
                in_tune     <= 1'b0;
                acc         <= '0;
                cnt         <= '0;
            end else begin
                idle <= idle_inc;
            end
        end
    end
endmodule

// File: tb/tb_tuner_note_ctrl.sv
// Directed bench for tuner_note_ctrl (TIMEOUT shortened to 100).
module tb_tuner_note_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        string_next = 1'b0;
    logic        period_valid = 1'b0;
    logic [19:0] period = '0;
    logic [2:0]  string_sel;
    logic [3:0]  note_code, status_code;
    logic        in_tune, result_pulse;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tuner_note_ctrl #(.TIMEOUT(100)) u_dut (
        .clk(clk), .reset(reset), .string_next(string_next),
        .period_valid(period_valid), .period(period),
        .string_sel(string_sel), .note_code(note_code), .status_code(status_code),
        .in_tune(in_tune), .result_pulse(result_pulse)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [19:0] p);
        period_valid = 1'b1; period = p;
        tick();
        period_valid = 1'b0; period = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (string_sel !== 3'd0)  begin errors++; $display("FAIL reset_sel: got %0d, expected 0", string_sel); end
        checks++; if (note_code !== 4'h0)   begin errors++; $display("FAIL reset_note: got %h, expected 0", note_code); end
        checks++; if (status_code !== 4'hF) begin errors++; $display("FAIL reset_status: got %h, expected F", status_code); end
        checks++; if (in_tune !== 1'b0)     begin errors++; $display("FAIL reset_in_tune: got %b, expected 0", in_tune); end
        checks++; if (result_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b, expected 0", result_pulse); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_in_tune();
        for (int i = 0; i < 3; i++) send(20'd606722);
        checks++; if (result_pulse !== 1'b0 || status_code !== 4'hF) begin errors++; $display("FAIL partial_batch: got pulse=%b status=%h, expected 0/F", result_pulse, status_code); end
        send(20'd606722);
        checks++; if (status_code !== 4'hE) begin errors++; $display("FAIL tune_status: got %h, expected E", status_code); end
        checks++; if (in_tune !== 1'b1)     begin errors++; $display("FAIL tune_in_tune: got %b, expected 1", in_tune); end
        checks++; if (result_pulse !== 1'b1) begin errors++; $display("FAIL tune_pulse: got %b, expected 1", result_pulse); end
        tick();
        checks++; if (result_pulse !== 1'b0 || status_code !== 4'hE) begin errors++; $display("FAIL tune_pulse_width: got pulse=%b status=%h, expected 0/E", result_pulse, status_code); end
    endtask

    task automatic test_flat_sharp();
        logic [19:0] pv [5] = '{20'd612000, 20'd600000, 20'd611462, 20'd601982, 20'd601981};
        logic [3:0]  ev [5] = '{4'h6, 4'h7, 4'hE, 4'hE, 4'h7};
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) send(pv[k]);
            checks++;
            if (status_code !== ev[k] || result_pulse !== 1'b1 || in_tune !== (ev[k] == 4'hE)) begin
                errors++;
                $display("FAIL compare_%0d: period %0d got status=%h pulse=%b in_tune=%b, expected %h/1/%b",
                         k, pv[k], status_code, result_pulse, in_tune, ev[k], ev[k] == 4'hE);
            end
        end
    endtask

    task automatic test_zero_discard();
        send(20'd612000); send(20'd0); send(20'd612000); send(20'd612000);
        checks++; if (result_pulse !== 1'b0) begin errors++; $display("FAIL zero_discard: got pulse=%b, expected 0", result_pulse); end
        send(20'd612000);
        checks++; if (result_pulse !== 1'b1 || status_code !== 4'h6) begin errors++; $display("FAIL zero_batch: got pulse=%b status=%h, expected 1/6", result_pulse, status_code); end
    endtask

    task automatic test_mid_reset();
        send(20'd600000); send(20'd600000);
        reset = 1'b1;
        tick();
        checks++; if (status_code !== 4'hF || in_tune !== 1'b0 || string_sel !== 3'd0 || result_pulse !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got status=%h in_tune=%b sel=%0d, expected F/0/0", status_code, in_tune, string_sel); end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send(20'd606722);
        checks++; if (result_pulse !== 1'b0) begin errors++; $display("FAIL reset_clears_count: got pulse=%b, expected 0", result_pulse); end
        send(20'd606722);
        checks++; if (result_pulse !== 1'b1 || status_code !== 4'hE) begin errors++; $display("FAIL after_reset_batch: got pulse=%b status=%h, expected 1/E", result_pulse, status_code); end
    endtask

    task automatic test_timeout();
        bit pulse_seen = 1'b0;
        for (int i = 0; i < 4; i++) send(20'd606722);
        checks++; if (status_code !== 4'hE) begin errors++; $display("FAIL timeout_pre: got %h, expected E", status_code); end
        for (int i = 0; i < 99; i++) begin
            tick();
            if (result_pulse) pulse_seen = 1'b1;
        end
        checks++; if (status_code !== 4'hE) begin errors++; $display("FAIL timeout_early: got %h after 99 idle cycles, expected E", status_code); end
        tick();
        checks++; if (status_code !== 4'hF || in_tune !== 1'b0) begin errors++; $display("FAIL timeout_fire: got status=%h in_tune=%b, expected F/0", status_code, in_tune); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (result_pulse) pulse_seen = 1'b1;
        end
        checks++; if (pulse_seen || status_code !== 4'hF) begin errors++; $display("FAIL timeout_hold: got pulse_seen=%b status=%h, expected 0/F", pulse_seen, status_code); end
        // A partial batch interrupted by timeout must not combine with later samples.
        send(20'd606722); send(20'd606722);
        for (int i = 0; i < 101; i++) tick();
        send(20'd606722); send(20'd606722);
        checks++; if (result_pulse !== 1'b0) begin errors++; $display("FAIL timeout_clears_acc: got pulse=%b, expected 0", result_pulse); end
        send(20'd606722); send(20'd606722);
        checks++; if (result_pulse !== 1'b1 || status_code !== 4'hE) begin errors++; $display("FAIL timeout_new_batch: got pulse=%b status=%h, expected 1/E", result_pulse, status_code); end
    endtask

`ifdef AUTO_STRING_EN
    task automatic test_auto_string();
        for (int i = 0; i < 4; i++) send(20'd455000);
        checks++; if (string_sel !== 3'd1 || note_code !== 4'h1 || status_code !== 4'hE) begin
            errors++; $display("FAIL auto_a2: got sel=%0d note=%h status=%h, expected 1/1/E", string_sel, note_code, status_code); end
        for (int i = 0; i < 4; i++) send(20'd250000);
        checks++; if (string_sel !== 3'd3 || status_code !== 4'h7) begin
            errors++; $display("FAIL auto_g3: got sel=%0d status=%h, expected 3/7", string_sel, status_code); end
        string_next = 1'b1; tick(); string_next = 1'b0;
        checks++; if (string_sel !== 3'd3 || status_code !== 4'h7) begin
            errors++; $display("FAIL auto_ignore_next: got sel=%0d status=%h, expected 3/7", string_sel, status_code); end
    endtask
`else
    task automatic test_string_next();
        for (int i = 0; i < 6; i++) begin
            string_next = 1'b1; tick(); string_next = 1'b0;
            checks++;
            if (string_sel !== 3'((i + 1) % 6) || note_code !== 4'((i + 1) % 6) || status_code !== 4'hF) begin
                errors++;
                $display("FAIL string_next_%0d: got sel=%0d note=%h status=%h, expected %0d/%0d/F",
                         i, string_sel, note_code, status_code, (i + 1) % 6, (i + 1) % 6);
            end
            if (i == 0) begin
                for (int j = 0; j < 4; j++) send(20'd454545);
                checks++; if (status_code !== 4'hE) begin errors++; $display("FAIL string1_tune: got %h, expected E", status_code); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) send(20'd606722);
        string_next = 1'b1; period_valid = 1'b1; period = 20'd454545;
        tick();
        string_next = 1'b0; period_valid = 1'b0; period = '0;
        checks++; if (string_sel !== 3'd1 || result_pulse !== 1'b0 || status_code !== 4'hF) begin
            errors++; $display("FAIL collision: got sel=%0d pulse=%b status=%h, expected 1/0/F", string_sel, result_pulse, status_code); end
        for (int i = 0; i < 3; i++) send(20'd454545);
        checks++; if (result_pulse !== 1'b0) begin errors++; $display("FAIL collision_discard: got pulse=%b, expected 0", result_pulse); end
        send(20'd454545);
        checks++; if (result_pulse !== 1'b1 || status_code !== 4'hE) begin errors++; $display("FAIL collision_batch: got pulse=%b status=%h, expected 1/E", result_pulse, status_code); end
    endtask
`endif

    initial begin
        test_reset();
        test_in_tune();
        test_flat_sharp();
        test_zero_discard();
        test_mid_reset();
        test_timeout();
`ifdef AUTO_STRING_EN
        test_auto_string();
`else
        test_string_next();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
